// File: rtl/jpeg_byte_packer.sv
// Packs jpeg_enc's compressed byte stream into 32-bit little-endian words with
// byte enables and an end-of-picture marker, buffered in a first-word-fall-through FIFO.
module jpeg_byte_packer #(
  parameter int FIFO_AW = 4
) (
  input  logic               ee_clk,
  input  logic               rst_ee,
  input  logic               data_valid_i,
  input  logic [7:0]         data_i,
  input  logic               pic_ready_i,
  output logic               word_valid_o,
  output logic [31:0]        word_o,
  output logic [3:0]         word_be_o,
  output logic               word_last_o,
  input  logic               word_ready_i,
  output logic [31:0]        pic_bytes_o,
  output logic               pic_done_o,
  output logic               overflow_o,
  output logic [FIFO_AW:0]   fifo_level_o
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [1:0]  cnt_reg;
  logic [7:0]  lane_reg [3];
  logic [31:0] byte_cnt_reg;
  logic [31:0] pic_bytes_reg;
  logic        pic_done_reg;
  logic        overflow_reg;

  logic [31:0] push_word;
  logic [3:0]  push_be;
  logic        push;
  logic        push_last;
  logic [2:0]  staged_n;
  logic [31:0] byte_cnt_next;

  // The same-cycle byte bypasses staging so a completing word is pushed in one step.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane_mux
      if (gi < 3) begin : g_staged
        assign push_word[8*gi +: 8] =
          (data_valid_i && cnt_reg == 2'(gi)) ? data_i : lane_reg[gi];
      end else begin : g_top
        assign push_word[8*gi +: 8] =
          (data_valid_i && cnt_reg == 2'(gi)) ? data_i : 8'h00;
      end
    end
  endgenerate

  assign staged_n      = {1'b0, cnt_reg} + {2'b00, data_valid_i};
  assign push          = pic_ready_i | (data_valid_i & (cnt_reg == 2'd3));
  assign push_last     = pic_ready_i;
  assign byte_cnt_next = byte_cnt_reg + {31'd0, data_valid_i};

  always_comb begin
    push_be = 4'b1111;
    case (staged_n)
      3'd0:    push_be = 4'b0000;
      3'd1:    push_be = 4'b0001;
      3'd2:    push_be = 4'b0011;
      3'd3:    push_be = 4'b0111;
      default: push_be = 4'b1111;
    endcase
  end

  always_ff @(posedge ee_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_ee || push) begin
        lane_reg[i] <= '0;
      end else if (data_valid_i && cnt_reg == 2'(i)) begin
        lane_reg[i] <= data_i;
      end
    end
  end

  always_ff @(posedge ee_clk) begin
    if (rst_ee) begin
      cnt_reg       <= '0;
      byte_cnt_reg  <= '0;
      pic_bytes_reg <= '0;
      pic_done_reg  <= 1'b0;
    end else begin
      pic_done_reg <= pic_ready_i;
      if (pic_ready_i) begin
        cnt_reg       <= '0;
        byte_cnt_reg  <= '0;
        pic_bytes_reg <= byte_cnt_next;
      end else begin
        cnt_reg      <= cnt_reg + {1'b0, data_valid_i};
        byte_cnt_reg <= byte_cnt_next;
      end
    end
  end

  // FIFO: entry = {last, be[3:0], data[31:0]}; head read straight from storage.
  logic [36:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   level_reg;
  logic               full;
  logic               empty;
  logic               pop;
  logic               wr_en;
  logic [36:0]        head;

  assign full  = level_reg[FIFO_AW];
  assign empty = (level_reg == '0);
  assign pop   = ~empty & word_ready_i;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge ee_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= {push_last, push_be, push_word};
    end
  end

  always_ff @(posedge ee_clk) begin
    if (rst_ee) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (push && full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign head = empty ? '0 : mem[rd_ptr_reg];

  assign word_valid_o = ~empty;
  assign word_o       = head[31:0];
  assign word_be_o    = head[35:32];
  assign word_last_o  = head[36];
  assign pic_bytes_o  = pic_bytes_reg;
  assign pic_done_o   = pic_done_reg;
  assign overflow_o   = overflow_reg;
  assign fifo_level_o = level_reg;

endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Directed bench for jpeg_byte_packer: hand-computed words, flush cases, overflow and reset.
`timescale 1ns/1ps
module tb_jpeg_byte_packer;

  localparam int AW = 4;

  logic          ee_clk = 1'b0;
  logic          rst_ee;
  logic          data_valid_i;
  logic [7:0]    data_i;
  logic          pic_ready_i;
  logic          word_valid_o;
  logic [31:0]   word_o;
  logic [3:0]    word_be_o;
  logic          word_last_o;
  logic          word_ready_i;
  logic [31:0]   pic_bytes_o;
  logic          pic_done_o;
  logic          overflow_o;
  logic [AW:0]   fifo_level_o;

  jpeg_byte_packer #(.FIFO_AW(AW)) dut (
    .ee_clk       (ee_clk),
    .rst_ee       (rst_ee),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .pic_ready_i  (pic_ready_i),
    .word_valid_o (word_valid_o),
    .word_o       (word_o),
    .word_be_o    (word_be_o),
    .word_last_o  (word_last_o),
    .word_ready_i (word_ready_i),
    .pic_bytes_o  (pic_bytes_o),
    .pic_done_o   (pic_done_o),
    .overflow_o   (overflow_o),
    .fifo_level_o (fifo_level_o)
  );

  always #5 ee_clk = ~ee_clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [36:0] obs_q[$];
  logic [36:0] exp_q[$];

  // Words are captured mid-cycle when the handshake will complete at the next edge.
  always @(negedge ee_clk) begin
    if (!rst_ee && word_valid_o && word_ready_i) obs_q.push_back({word_last_o, word_be_o, word_o});
    if (pic_done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ee_clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input logic pr);
    data_valid_i = 1'b1;
    data_i       = b;
    pic_ready_i  = pr;
    tick();
    data_valid_i = 1'b0;
    data_i       = 8'h00;
    pic_ready_i  = 1'b0;
  endtask

  task automatic flush();
    pic_ready_i = 1'b1;
    tick();
    pic_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ee = 1'b1;
    tick();
    tick();
    rst_ee = 1'b0;
  endtask

  task automatic exp_word(input logic last, input logic [3:0] be, input logic [31:0] d);
    exp_q.push_back({last, be, d});
  endtask

  function automatic logic [31:0] seq_word(input int j);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(4*j + b);
    return w;
  endfunction

  task automatic check_drain(input string tag);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk({tag, " count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) chk($sformatf("%s word%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0;
    rst_ee       = 1'b1;
    data_valid_i = 1'b0;
    data_i       = 8'h00;
    pic_ready_i  = 1'b0;
    word_ready_i = 1'b1;
    do_reset();
    chk("rst valid", 64'(word_valid_o), 64'd0);
    chk("rst word", 64'({word_last_o, word_be_o, word_o}), 64'd0);
    chk("rst pic_bytes", 64'(pic_bytes_o), 64'd0);
    chk("rst pic_done", 64'(pic_done_o), 64'd0);
    chk("rst overflow", 64'(overflow_o), 64'd0);
    chk("rst level", 64'(fifo_level_o), 64'd0);

    // Eight bytes then a flush on an idle cycle: two full words plus a marker.
    d0 = done_cnt;
    for (int i = 1; i <= 4; i++) put(8'(i), 1'b0);
    chk("t1 latency valid", 64'(word_valid_o), 64'd1);
    chk("t1 latency word", 64'({word_last_o, word_be_o, word_o}), 64'({1'b0, 4'hF, 32'h04030201}));
    chk("t1 latency level", 64'(fifo_level_o), 64'd1);
    for (int i = 5; i <= 8; i++) put(8'(i), 1'b0);
    flush();
    chk("t1 pic_done", 64'(pic_done_o), 64'd1);
    chk("t1 pic_bytes", 64'(pic_bytes_o), 64'd8);
    exp_word(1'b0, 4'hF, 32'h04030201);
    exp_word(1'b0, 4'hF, 32'h08070605);
    exp_word(1'b1, 4'h0, 32'h00000000);
    check_drain("t1");
    chk("t1 done pulses", 64'(done_cnt - d0), 64'd1);

    // Five bytes, flush later: one full word and a one-byte tail.
    for (int i = 0; i < 5; i++) put(8'(8'h11 + i), 1'b0);
    tick();
    flush();
    chk("t2 pic_bytes", 64'(pic_bytes_o), 64'd5);
    exp_word(1'b0, 4'hF, 32'h14131211);
    exp_word(1'b1, 4'h1, 32'h00000015);
    check_drain("t2");

    // Flush on the 7th byte, then on a word-completing 4th byte, then with no bytes.
    for (int i = 0; i < 6; i++) put(8'(8'hA1 + i), 1'b0);
    put(8'hA7, 1'b1);
    chk("t3 pic_bytes7", 64'(pic_bytes_o), 64'd7);
    for (int i = 0; i < 3; i++) put(8'(8'hB1 + i), 1'b0);
    put(8'hB4, 1'b1);
    chk("t3 pic_bytes4", 64'(pic_bytes_o), 64'd4);
    flush();
    chk("t3 pic_bytes0", 64'(pic_bytes_o), 64'd0);
    exp_word(1'b0, 4'hF, 32'hA4A3A2A1);
    exp_word(1'b1, 4'h7, 32'h00A7A6A5);
    exp_word(1'b1, 4'hF, 32'hB4B3B2B1);
    exp_word(1'b1, 4'h0, 32'h00000000);
    check_drain("t3");

    // Sink stalled: 17 words offered, 16 kept, 17th dropped.
    word_ready_i = 1'b0;
    for (int i = 0; i < 68; i++) put(8'(i), 1'b0);
    chk("t4 level full", 64'(fifo_level_o), 64'd16);
    chk("t4 overflow", 64'(overflow_o), 64'd1);
    chk("t4 head", 64'(word_o), 64'(seq_word(0)));
    for (int j = 0; j < 16; j++) exp_word(1'b0, 4'hF, seq_word(j));
    word_ready_i = 1'b1;
    check_drain("t4");
    chk("t4 level empty", 64'(fifo_level_o), 64'd0);
    chk("t4 overflow sticky", 64'(overflow_o), 64'd1);

    // Full FIFO, ready toggling; pushes land only on ready cycles so push+pop hold level.
    word_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 64; i++) put(8'(i), 1'b0);
    chk("t5 level fill", 64'(fifo_level_o), 64'd16);
    for (int j = 0; j < 16; j++) exp_word(1'b0, 4'hF, seq_word(j));
    for (int k = 0; k < 8; k++) begin
      word_ready_i = 1'b1;
      put(8'(8'h50 + k), 1'b1);
      chk($sformatf("t5 level k%0d", k), 64'(fifo_level_o), 64'd16);
      exp_word(1'b1, 4'h1, {24'd0, 8'(8'h50 + k)});
      word_ready_i = 1'b0;
      tick();
    end
    chk("t5 overflow", 64'(overflow_o), 64'd0);
    word_ready_i = 1'b1;
    check_drain("t5");

    // Reset mid-picture discards the partial word.
    for (int i = 0; i < 3; i++) put(8'(8'hE1 + i), 1'b0);
    rst_ee = 1'b1;
    tick();
    rst_ee = 1'b0;
    for (int i = 0; i < 3; i++) put(8'(8'hC1 + i), 1'b0);
    put(8'hC4, 1'b1);
    chk("t6 pic_bytes", 64'(pic_bytes_o), 64'd4);
    chk("t6 overflow", 64'(overflow_o), 64'd0);
    exp_word(1'b1, 4'hF, 32'hC4C3C2C1);
    check_drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_packer.md
Name: jpeg_byte_packer

Overview:
Downstream consumer of jpeg_enc's compressed byte stream (data_valid/data_out/pic_ready) in the ee_clk domain. It packs bytes into 32-bit little-endian words, flushes a partial word at end of picture, and marks the picture boundary. Packed words are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake for a memory writer or gether_mac_tx-style sink. It also reports the byte count of each completed picture.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words (default 16).

Ports:
ee_clk  input  1  encoder-domain clock; all logic on rising edge.
rst_ee  input  1  synchronous reset, active-high.
data_valid_i  input  1  byte strobe from jpeg_enc.
data_i  input  8  compressed byte.
pic_ready_i  input  1  one-cycle end-of-picture pulse from jpeg_enc.
word_valid_o  output  1  FIFO head valid.
word_o  output  32  packed word; first byte of group in [7:0].
word_be_o  output  4  byte enables; bit k set = byte lane k valid.
word_last_o  output  1  head word closes a picture.
word_ready_i  input  1  sink accepts head when word_valid_o & word_ready_i.
pic_bytes_o  output  32  byte count of last completed picture (held).
pic_done_o  output  1  one-cycle pulse on picture flush.
overflow_o  output  1  sticky: a push was dropped because FIFO was full.
fifo_level_o  output  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (rst_ee=1 at edge): lane counter=0, staging register=0, running byte count=0, FIFO empty. All outputs 0: word_valid_o, word_o, word_be_o, word_last_o, pic_bytes_o, pic_done_o, overflow_o, fifo_level_o. Reset mid-picture discards the partial word and all FIFO contents.
- Packing: each data_valid_i cycle writes data_i into lane[cnt] and increments cnt (2-bit, wraps 3->0). The running count increments by 1 (32-bit, wraps silently).
- When the 4th byte is accepted (cnt==3) without pic_ready_i, push {byte3,byte2,byte1,byte0}, be=4'b1111, last=0. The staging register clears.
- pic_ready_i (flush), evaluated after any same-cycle byte:
  - Total bytes staged n in 1..3: push the partial word. Unused lanes are 0, be has the low n bits set, last=1.
  - n==4 (byte completing a word on the same cycle): push the full word with be=4'b1111, last=1.
  - n==0: push a marker word with data 0, be=4'b0000, last=1.
  - cnt and the running count clear to 0.
  - pic_bytes_o takes the final count, including the same-cycle byte.
  - pic_done_o pulses for exactly that cycle.
- Exactly one push occurs per cycle at most; bytes and flush cannot produce two pushes.
- FIFO: registered storage, FWFT. A word pushed at edge N appears on word_o with word_valid_o=1 after edge N when the FIFO was empty (1-cycle latency).
  - Pop happens when word_valid_o & word_ready_i.
  - Simultaneous push and pop is allowed at any level, including full (level unchanged).
  - Push when full with no pop: the word is dropped, overflow_o sets and stays set until reset, level stays 2**FIFO_AW.
  - Pointers wrap modulo depth.
  - word_o, word_be_o, and word_last_o are don't-care-free: they read 0 when empty.
- fifo_level_o updates at the same edge as push/pop.
- pic_ready_i with no bytes ever received still emits a marker word and pic_bytes_o=0.

Test Plan:
- Bytes 0x01..0x08 on consecutive cycles, then pic_ready_i -> words 0x04030201 be=F, 0x08070605 be=F, then marker 0x00000000 be=0 last=1. pic_bytes_o=8, one pic_done_o pulse.
- Bytes 0x11..0x15, pic_ready_i on a later idle cycle -> 0x14131211 be=F, 0x00000015 be=4'b0001 last=1, pic_bytes_o=5.
- Bytes 0xA1..0xA7 with pic_ready_i asserted on the 7th byte's cycle -> 0xA4A3A2A1 be=F, 0x00A7A6A5 be=4'b0111 last=1, pic_bytes_o=7. A following 4-byte picture ending on its 4th byte -> single word be=F last=1, pic_bytes_o=4.
- word_ready_i=0, 68 bytes (17 words) -> fifo_level_o=16, overflow_o=1, and the 17th word is absent. Then word_ready_i=1 -> 16 words drain in order, level goes to 0, overflow_o stays 1.
- Continuous stream with word_ready_i toggling every cycle and FIFO full -> push+pop on the same edge keeps level at 16, no overflow, and the output order matches input.
- 3 bytes, then rst_ee=1 for one cycle, then bytes 0xC1..0xC4 + pic_ready_i -> only 0xC4C3C2C1 be=F last=1 is output, pic_bytes_o=4, overflow_o=0.
